// File: rtl/jpeg_cone_pkg.sv
// Shared types and helpers for the pipelined JPEG majority/AOI cone block.
package jpeg_cone_pkg;

    localparam int CNT_W = 16;
    localparam int MAJ_W = 64;

    typedef enum logic {
        MODE_INV = 1'b0,
        MODE_XOR = 1'b1
    } cone_mode_e;

    // Bitwise 3-input majority; callers zero-extend narrower operands.
    function automatic logic [MAJ_W-1:0] maj3(
        input logic [MAJ_W-1:0] a,
        input logic [MAJ_W-1:0] b,
        input logic [MAJ_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/jpeg_cone_stage.sv
// One elastic valid/ready register stage; ready is combinational from downstream.
module jpeg_cone_stage
    import jpeg_cone_pkg::*;
#(
    parameter int DW         = 9,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    assign s_ready = ~valid_r | m_ready;
    assign m_valid = valid_r;
    assign m_data  = data_r;

    // Occupancy: reload from upstream whenever this stage can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (s_ready) begin
            valid_r <= s_valid;
        end
    end

    // Payload only captured on a real transfer, so idle X never enters.
    always_ff @(posedge clk) begin
        if (rst && RESET_DATA) begin
            data_r <= {DW{1'b0}};
        end else if (s_ready && s_valid) begin
            data_r <= s_data;
        end
    end

endmodule

// File: rtl/jpeg_cone_pipe.sv
// NCH parallel majority/AOI cones, optional OR-reduction, elastic output pipeline
// and a completed-transfer counter.
module jpeg_cone_pipe
    import jpeg_cone_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NCH         = 4,
    parameter int PIPE_STAGES = 2,
    parameter int REDUCE      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] a,
    input  logic [NCH*WIDTH-1:0] b,
    input  logic [NCH*WIDTH-1:0] c,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [NCH*WIDTH-1:0] e,
    input  logic [NCH*WIDTH-1:0] f,
    input  logic [NCH-1:0]       sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] y,
    output logic                 y_any,
    output logic [CNT_W-1:0]     out_cnt
);

    localparam int DW = NCH*WIDTH + 1;

    logic [NCH*WIDTH-1:0] y_cone_s;
    logic                 y_any_s;
    logic                 valid_s [0:PIPE_STAGES];
    logic                 ready_s [0:PIPE_STAGES];
    logic [DW-1:0]        data_s  [0:PIPE_STAGES];
    logic [CNT_W-1:0]     out_cnt_r;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] t0_s;
        logic [WIDTH-1:0] t1_s;
        logic [WIDTH-1:0] y_ch_s;

        assign t0_s = WIDTH'(maj3(MAJ_W'(a[i*WIDTH +: WIDTH]),
                                  MAJ_W'(b[i*WIDTH +: WIDTH]),
                                  MAJ_W'(c[i*WIDTH +: WIDTH])));
        assign t1_s = ~((t0_s & d[i*WIDTH +: WIDTH]) | e[i*WIDTH +: WIDTH]);

        // Per-channel output mode select.
        always_comb begin
            y_ch_s = ~t1_s;
            case (cone_mode_e'(sel[i]))
                MODE_XOR: y_ch_s = t1_s ^ f[i*WIDTH +: WIDTH];
                MODE_INV: y_ch_s = ~t1_s;
                default:  y_ch_s = ~t1_s;
            endcase
        end

        assign y_cone_s[i*WIDTH +: WIDTH] = y_ch_s;
    end

    // Summary bit is formed before stage 0 and travels with its data.
    if (REDUCE != 0) begin : g_reduce
        assign y_any_s = |y_cone_s;
    end else begin : g_no_reduce
        assign y_any_s = 1'b0;
    end

    assign valid_s[0]           = in_valid;
    assign data_s[0]            = {y_any_s, y_cone_s};
    assign ready_s[PIPE_STAGES] = out_ready;
    assign in_ready             = ready_s[0];

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        jpeg_cone_stage #(
            .DW         (DW),
            .RESET_DATA ((k == PIPE_STAGES-1) ? 1'b1 : 1'b0)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .s_valid (valid_s[k]),
            .s_ready (ready_s[k]),
            .s_data  (data_s[k]),
            .m_valid (valid_s[k+1]),
            .m_ready (ready_s[k+1]),
            .m_data  (data_s[k+1])
        );
    end

    assign out_valid = valid_s[PIPE_STAGES];
    assign y         = data_s[PIPE_STAGES][DW-2:0];
    assign y_any     = data_s[PIPE_STAGES][DW-1];
    assign out_cnt   = out_cnt_r;

    // Completed output transfers; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready) begin
            out_cnt_r <= out_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_jpeg_cone_pipe.sv
// Directed bench for jpeg_cone_pipe: single-channel instance for the hand vectors,
// a 4-channel unreduced instance against a reference model.
module tb_jpeg_cone_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, y_any;
    logic [7:0]  a, b, c, d, e, f, y;
    logic [0:0]  sel;
    logic [15:0] out_cnt;

    logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_y_any;
    logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_y;
    logic [3:0]  r_sel;
    logic [15:0] r_out_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jpeg_cone_pipe #(.WIDTH(8), .NCH(1), .PIPE_STAGES(2), .REDUCE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_any(y_any),
        .out_cnt(out_cnt)
    );

    jpeg_cone_pipe #(.WIDTH(8), .NCH(4), .PIPE_STAGES(3), .REDUCE(0)) dut4 (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .a(r_a), .b(r_b), .c(r_c), .d(r_d), .e(r_e), .f(r_f), .sel(r_sel),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .y(r_y), .y_any(r_y_any),
        .out_cnt(r_out_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref4(input logic [31:0] ra, rb, rc, rd, re, rf,
                                         input logic [3:0] rs);
        logic [31:0] t0, t1, res;
        t0 = (ra & rb) | (ra & rc) | (rb & rc);
        t1 = ~((t0 & rd) | re);
        for (int ch = 0; ch < 4; ch++)
            res[ch*8 +: 8] = rs[ch] ? (t1[ch*8 +: 8] ^ rf[ch*8 +: 8]) : ~t1[ch*8 +: 8];
        return res;
    endfunction

    task automatic idle_x();
        in_valid = 1'b0;
        a = 8'hxx; b = 8'hxx; c = 8'hxx; d = 8'hxx; e = 8'hxx; f = 8'hxx;
    endtask

    task automatic drive_pass(input logic [7:0] v);
        in_valid = 1'b1;
        a = v; b = v; c = 8'h00; d = 8'hFF; e = 8'h00; f = 8'h00; sel = 1'b0;
    endtask

    task automatic send1(input string tag, input logic [7:0] av, bv, cv, dv, ev, fv,
                         input logic sv, input logic [7:0] ey, input logic eany);
        in_valid = 1'b1;
        a = av; b = bv; c = cv; d = dv; e = ev; f = fv; sel = sv;
        cycle();
        idle_x();
        check_eq({tag, "_lat1"}, 64'(out_valid), 64'h0);
        cycle();
        check_eq({tag, "_valid"}, 64'(out_valid), 64'h1);
        check_eq({tag, "_y"}, 64'(y), 64'(ey));
        check_eq({tag, "_any"}, 64'(y_any), 64'(eany));
        cycle();
    endtask

    initial begin
        int sent, rcv, stall, acc, stale, n_out;
        logic hold_pend;
        logic [31:0] exp_q[$];
        logic [31:0] ev;

        rst = 1'b1; out_ready = 1'b1; sel = 1'b0;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00; e = 8'h00; f = 8'h00;
        r_in_valid = 1'b0; r_out_ready = 1'b1; r_sel = 4'h0;
        r_a = 32'h0; r_b = 32'h0; r_c = 32'h0; r_d = 32'h0; r_e = 32'h0; r_f = 32'h0;
        cycle();
        cycle();
        rst = 1'b0;
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_in_ready", 64'(in_ready), 64'h1);
        check_eq("rst_y", 64'(y), 64'h0);
        check_eq("rst_y_any", 64'(y_any), 64'h0);
        check_eq("rst_cnt", 64'(out_cnt), 64'h0);

        // Hand-computed cone vectors
        send1("maj_inv", 8'hF0, 8'hCC, 8'hAA, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hE8, 1'b1);
        send1("maj_xor", 8'hF0, 8'hCC, 8'hAA, 8'hFF, 8'h00, 8'h0F, 1'b1, 8'h18, 1'b1);
        send1("force_e", 8'hF0, 8'hCC, 8'hAA, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b1);
        send1("zero_any", 8'hF0, 8'hCC, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("cnt_after_vec", 64'(out_cnt), 64'h4);

        // Back-to-back stream of 10
        sent = 0; rcv = 0; stall = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (out_valid) begin
                check_eq("stream_y", 64'(y), 64'(8'h10 + rcv));
                rcv++;
            end
            if (sent < 10) begin
                drive_pass(8'(8'h10 + sent));
                if (!in_ready) stall++;
                sent++;
            end else begin
                idle_x();
            end
            cycle();
        end
        check_eq("stream_stall", 64'(stall), 64'h0);
        check_eq("stream_rcv", 64'(rcv), 64'd10);
        check_eq("stream_cnt", 64'(out_cnt), 64'd14);
        check_eq("stream_no_x", 64'(y), 64'h19);

        // Backpressure: fill, hold, release
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i >= 3) begin
                check_eq("hold_valid", 64'(out_valid), 64'h1);
                check_eq("hold_y", 64'(y), 64'h20);
                check_eq("hold_in_ready", 64'(in_ready), 64'h0);
            end
            drive_pass(8'(8'h20 + acc));
            #2;
            if (in_ready) acc++;
            cycle();
        end
        check_eq("hold_accepts", 64'(acc), 64'h2);
        idle_x();
        out_ready = 1'b1; rcv = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin
                check_eq("drain_y", 64'(y), 64'(8'h20 + rcv));
                rcv++;
            end
            cycle();
        end
        check_eq("drain_rcv", 64'(rcv), 64'h2);
        check_eq("drain_cnt", 64'(out_cnt), 64'd16);

        // Reset with two transfers in flight and a handshake during reset
        drive_pass(8'h30);
        cycle();
        drive_pass(8'h31);
        cycle();
        drive_pass(8'h32);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle_x();
        check_eq("mid_rst_valid", 64'(out_valid), 64'h0);
        check_eq("mid_rst_y", 64'(y), 64'h0);
        check_eq("mid_rst_any", 64'(y_any), 64'h0);
        check_eq("mid_rst_cnt", 64'(out_cnt), 64'h0);
        check_eq("mid_rst_ready", 64'(in_ready), 64'h1);
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) stale++;
            cycle();
        end
        check_eq("mid_rst_stale", 64'(stale), 64'h0);
        check_eq("mid_rst_cnt2", 64'(out_cnt), 64'h0);

        // Counter wrap
        drive_pass(8'h40);
        repeat (65534) cycle();
        idle_x();
        repeat (4) cycle();
        check_eq("cnt_fffe", 64'(out_cnt), 64'hFFFE);
        drive_pass(8'h41);
        repeat (3) cycle();
        idle_x();
        repeat (4) cycle();
        check_eq("cnt_wrap", 64'(out_cnt), 64'h0001);

        // Randomised 4-channel, no reduction, 3 stages
        hold_pend = 1'b0; n_out = 0;
        for (int i = 0; i < 320; i++) begin
            if (hold_pend) check_eq("r_hold_valid", 64'(r_out_valid), 64'h1);
            r_out_ready = (i >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
            r_in_valid  = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_a = $urandom; r_b = $urandom; r_c = $urandom;
            r_d = $urandom; r_e = $urandom & $urandom; r_f = $urandom;
            r_sel = 4'($urandom);
            #2;
            if (r_out_valid && r_out_ready) begin
                check_eq("r_nonempty", 64'(exp_q.size() > 0), 64'h1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check_eq("r_y", 64'(r_y), 64'(ev));
                end
                check_eq("r_y_any", 64'(r_y_any), 64'h0);
                n_out++;
            end
            if (r_in_valid && r_in_ready)
                exp_q.push_back(ref4(r_a, r_b, r_c, r_d, r_e, r_f, r_sel));
            hold_pend = r_out_valid && !r_out_ready;
            cycle();
        end
        check_eq("r_leftover", 64'(exp_q.size()), 64'h0);
        check_eq("r_cnt", 64'(r_out_cnt), 64'(n_out));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
